// File: rtl/filter_peak_extractor.sv
// Peak extractor for trapezoidal filter output: amplitude, peak timestamp and width per pulse,
// one-deep event buffer with hold-off and drop counting. Optional pile-up flag: PEAK_PILEUP_EN.
module filter_peak_extractor #(
    parameter int DATA_W    = 20,
    parameter int TS_W      = 32,
    parameter int WIDTH_W   = 8,
    parameter int HOLDOFF   = 16,
    parameter int MAX_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] filt_data,
    input  logic signed [DATA_W-1:0] threshold,
    output logic signed [DATA_W-1:0] out_amp,
    output logic        [TS_W-1:0]   out_ts,
    output logic        [WIDTH_W-1:0] out_width,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [15:0]       drop_cnt,
    output logic                     busy
`ifdef PEAK_PILEUP_EN
    ,
    output logic                     out_pileup
`endif
);
    // state   | meaning
    // S_IDLE  | armed, waiting for a sample above threshold
    // S_TRACK | inside a pulse, tracking maximum and width
    // S_HOLD  | dead time after an event, input ignored until re-arm
    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD} state_t;

    localparam logic [7:0]         HOLD_LIM  = 8'(HOLDOFF);
    localparam logic [WIDTH_W-1:0] WIDTH_SAT = '1;

    state_t                    state_q, state_d;
    logic [TS_W-1:0]           ts_q, ts_d, pts_q, pts_d;
    logic signed [DATA_W-1:0]  max_q, max_d, thr_q, thr_d;
    logic [WIDTH_W-1:0]        width_q, width_d;
    logic [7:0]                hold_q, hold_d;
    logic                      post, load;
    logic signed [DATA_W-1:0]  out_amp_q, out_amp_d;
    logic [TS_W-1:0]           out_ts_q, out_ts_d;
    logic [WIDTH_W-1:0]        out_width_q, out_width_d;
    logic                      out_valid_q, out_valid_d;
    logic [15:0]               drop_q, drop_d;
    logic                      busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        pts_d   = pts_q;
        width_d = width_q;
        thr_d   = thr_q;
        hold_d  = hold_q;
        post    = 1'b0;
        ts_d    = ts_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (filt_data > threshold) begin
                    state_d = S_TRACK;
                    max_d   = filt_data;
                    pts_d   = ts_q;
                    width_d = WIDTH_W'(1);
                    thr_d   = threshold;
                end
            end
            S_TRACK: begin
                if (filt_data > thr_q) begin
                    if (width_q != WIDTH_SAT) width_d = width_q + 1'b1;
                    // strict compare keeps the first sample of a flat top
                    if (filt_data > max_q) begin
                        max_d = filt_data;
                        pts_d = ts_q;
                    end
                end else begin
                    post    = 1'b1;
                    state_d = S_HOLD;
                    hold_d  = '0;
                end
            end
            S_HOLD: begin
                if (hold_q != 8'hFF) hold_d = hold_q + 8'd1;
                if (hold_q >= HOLD_LIM && filt_data <= thr_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A post into an occupied slot that is not draining this edge is dropped.
    always_comb begin
        load        = post && (!out_valid_q || out_ready);
        out_valid_d = post || (out_valid_q && !out_ready);
        out_amp_d   = load ? max_q   : out_amp_q;
        out_ts_d    = load ? pts_q   : out_ts_q;
        out_width_d = load ? width_q : out_width_q;
        drop_d      = drop_q;
        if (post && out_valid_q && !out_ready && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ts_q        <= '0;
            pts_q       <= '0;
            max_q       <= '0;
            thr_q       <= '0;
            width_q     <= '0;
            hold_q      <= '0;
            out_amp_q   <= '0;
            out_ts_q    <= '0;
            out_width_q <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            pts_q       <= pts_d;
            max_q       <= max_d;
            thr_q       <= thr_d;
            width_q     <= width_d;
            hold_q      <= hold_d;
            out_amp_q   <= out_amp_d;
            out_ts_q    <= out_ts_d;
            out_width_q <= out_width_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
            busy_q      <= busy_d;
        end
    end

    assign out_amp   = out_amp_q;
    assign out_ts    = out_ts_q;
    assign out_width = out_width_q;
    assign out_valid = out_valid_q;
    assign drop_cnt  = drop_q;
    assign busy      = busy_q;

`ifdef PEAK_PILEUP_EN
    logic signed [DATA_W-1:0] valley_q, valley_d;
    logic                     dp_q, dp_d, out_pileup_q, out_pileup_d;
    logic signed [DATA_W:0]   half, fall, rise;
    logic                     wide;

    // valley is the lowest sample since the current maximum was set
    always_comb begin
        valley_d     = valley_q;
        dp_d         = dp_q;
        half         = ((DATA_W+1)'(max_q) - (DATA_W+1)'(thr_q)) >>> 1;
        fall         = (DATA_W+1)'(max_q) - (DATA_W+1)'(valley_q);
        rise         = (DATA_W+1)'(filt_data) - (DATA_W+1)'(valley_q);
        wide         = int'(width_q) > MAX_WIDTH;
        out_pileup_d = load ? (dp_q || wide) : out_pileup_q;
        if (state_q == S_IDLE) begin
            valley_d = filt_data;
            dp_d     = 1'b0;
        end else if (state_q == S_TRACK && filt_data > thr_q) begin
            if (fall > half && rise > half) dp_d = 1'b1;
            if (filt_data > max_q || filt_data < valley_q) valley_d = filt_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valley_q     <= '0;
            dp_q         <= 1'b0;
            out_pileup_q <= 1'b0;
        end else begin
            valley_q     <= valley_d;
            dp_q         <= dp_d;
            out_pileup_q <= out_pileup_d;
        end
    end

    assign out_pileup = out_pileup_q;
`endif

endmodule

// File: tb/tb_filter_peak_extractor.sv
// Scoreboard bench for filter_peak_extractor: a pulse-segment reference model predicts every
// transfer, busy per cycle and drop count; a negedge monitor compares what the DUT presents.
module tb_filter_peak_extractor;
    localparam int DATA_W    = 20;
    localparam int TS_W      = 32;
    localparam int WIDTH_W   = 8;
    localparam int HOLDOFF   = 16;
    localparam int MAX_WIDTH = 64;
    localparam int NMAX      = 2000;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic signed [DATA_W-1:0]  filt_data = '0;
    logic signed [DATA_W-1:0]  threshold = '0;
    logic signed [DATA_W-1:0]  out_amp;
    logic        [TS_W-1:0]    out_ts;
    logic        [WIDTH_W-1:0] out_width;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic        [15:0]        drop_cnt;
    logic                      busy;
`ifdef PEAK_PILEUP_EN
    logic                      out_pileup;
`endif

    filter_peak_extractor #(
        .DATA_W(DATA_W), .TS_W(TS_W), .WIDTH_W(WIDTH_W),
        .HOLDOFF(HOLDOFF), .MAX_WIDTH(MAX_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .filt_data(filt_data), .threshold(threshold),
        .out_amp(out_amp), .out_ts(out_ts), .out_width(out_width), .out_valid(out_valid),
        .out_ready(out_ready), .drop_cnt(drop_cnt), .busy(busy)
`ifdef PEAK_PILEUP_EN
        , .out_pileup(out_pileup)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int amp; int ts; int width; bit pu; } ev_t;

    int   s[NMAX];
    bit   r[NMAX];
    bit   busy_exp[NMAX];
    bit   ev_has[NMAX];
    ev_t  ev_at[NMAX];
    ev_t  exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   drop_exp = 0;
    bit   run_active = 1'b0;
    bit   occ_end = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: find each pulse as a run of samples above threshold, then replay the output slot.
    task automatic run_model(input int thr, input int n);
        int  c, i, e, k, m, q, vm, vq, valley, half;
        bit  occ, xfer;
        ev_t ev, slot;
        for (int j = 0; j < n; j++) begin busy_exp[j] = 0; ev_has[j] = 0; end
        drop_exp = 0;
        exp_q.delete();
        slot = '{0, 0, 0, 0, 0};
        c = 0;
        while (c < n) begin
            if (s[c] > thr) begin
                i = c; e = c;
                while (e < n && s[e] > thr) e++;
                if (e >= n) break;
                m = s[i]; q = i;
                for (int j = i; j < e; j++) if (s[j] > m) begin m = s[j]; q = j; end
                ev.amp = m; ev.ts = q; ev.cyc = 0;
                ev.width = (e - i > 255) ? 255 : e - i;
                ev.pu = (e - i) > MAX_WIDTH;
                for (int j = i + 1; j < e; j++) begin
                    vm = s[i]; vq = i;
                    for (int t = i; t < j; t++) if (s[t] > vm) begin vm = s[t]; vq = t; end
                    valley = s[vq];
                    for (int t = vq; t < j; t++) if (s[t] < valley) valley = s[t];
                    half = (vm - thr) / 2;
                    if (vm - valley > half && s[j] - valley > half) ev.pu = 1;
                end
                ev_has[e] = 1; ev_at[e] = ev;
                k = e + 1 + HOLDOFF;
                while (k < n && s[k] > thr) k++;
                for (int j = i + 1; j <= k && j < n; j++) busy_exp[j] = 1;
                c = k + 1;
            end else c++;
        end
        occ = 0;
        for (int j = 0; j < n; j++) begin
            xfer = occ && r[j];
            if (xfer) begin slot.cyc = j; exp_q.push_back(slot); end
            if (ev_has[j]) begin
                if (occ && !xfer) begin if (drop_exp < 65535) drop_exp++; end
                else begin slot = ev_at[j]; occ = 1; end
            end else if (xfer) occ = 0;
        end
        occ_end = occ;
    endtask

    always @(negedge clk) begin
        if (run_active) begin
            ev_t e;
            chk("busy", longint'(busy), longint'(busy_exp[cyc]));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_transfer", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_cycle", cyc, e.cyc);
                    chk("out_amp", longint'(out_amp), e.amp);
                    chk("out_ts", longint'(out_ts), e.ts);
                    chk("out_width", longint'(out_width), e.width);
`ifdef PEAK_PILEUP_EN
                    chk("out_pileup", longint'(out_pileup), longint'(e.pu));
`endif
                end
            end
        end
    end

    task automatic run_scenario(input int thr, input int n);
        run_model(thr, n);
        run_active = 1'b0;
        reset = 1'b0; threshold = DATA_W'(thr); filt_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_drop_cnt", longint'(drop_cnt), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_out_amp", longint'(out_amp), 0);
        reset = 1'b1; filt_data = DATA_W'(s[0]); out_ready = r[0]; cyc = 0; run_active = 1'b1;
        for (int c = 1; c < n; c++) begin
            @(posedge clk); #1;
            filt_data = DATA_W'(s[c]); out_ready = r[c]; cyc = c;
        end
        @(posedge clk); #1;
        run_active = 1'b0;
        chk("drop_cnt", longint'(drop_cnt), drop_exp);
        chk("pending_events", exp_q.size(), 0);
        chk("out_valid_end", longint'(out_valid), longint'(occ_end));
    endtask

    task automatic clear_stim(input int n, input bit rdy);
        for (int j = 0; j < n; j++) begin s[j] = 0; r[j] = rdy; end
    endtask

    task automatic put_pulse(input int at, input int v0, input int v1, input int v2,
                             input int v3, input int v4, input int v5);
        s[at] = v0; s[at+1] = v1; s[at+2] = v2; s[at+3] = v3; s[at+4] = v4; s[at+5] = v5;
    endtask

    task automatic gen_random(input int thr, input int n);
        int c, gap, len, base, bias;
        c = 0;
        bias = int'($urandom_range(3, 10));
        while (c < n - 300) begin
            gap = int'($urandom_range(0, 40));
            for (int g = 0; g < gap && c < n - 300; g++) begin
                s[c] = ($urandom_range(0, 7) == 0) ? thr : thr - int'($urandom_range(1, 300));
                c++;
            end
            len  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(200, 290))
                                                 : int'($urandom_range(1, 80));
            base = thr + int'($urandom_range(50, 2000));
            for (int p = 0; p < len && c < n - 300; p++) begin
                case ($urandom_range(0, 3))
                    0:       s[c] = thr + 1;
                    1:       s[c] = base;
                    2:       s[c] = base - int'($urandom_range(0, 40));
                    default: s[c] = thr + int'($urandom_range(1, 3000));
                endcase
                c++;
            end
        end
        while (c < n) begin s[c] = thr - 5; c++; end
        for (int j = 0; j < n; j++) r[j] = (j >= n - 300) || (int'($urandom_range(0, 9)) < bias);
    endtask

    task automatic reset_mid_track();
        run_active = 1'b0;
        reset = 1'b0; threshold = DATA_W'(100); filt_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(posedge clk); #1;
            cyc = c;
            filt_data = (c >= 5 && c <= 7) ? DATA_W'(300) : (c >= 30) ? DATA_W'(250) : '0;
        end
        #2;
        chk("pre_reset_busy", longint'(busy), 1);
        chk("pre_reset_valid", longint'(out_valid), 1);
        chk("pre_reset_amp", longint'(out_amp), 300);
        reset = 1'b0;
        #1;
        chk("async_rst_valid", longint'(out_valid), 0);
        chk("async_rst_amp", longint'(out_amp), 0);
        chk("async_rst_ts", longint'(out_ts), 0);
        chk("async_rst_width", longint'(out_width), 0);
        chk("async_rst_busy", longint'(busy), 0);
    endtask

    initial begin
        int thr;
        // quiet input
        clear_stim(60, 1'b1);
        run_scenario(100, 60);
        // single pulse, first 150 at counter 10
        clear_stim(80, 1'b1);
        put_pulse(9, 50, 150, 300, 300, 200, 90);
        run_scenario(100, 80);
        // consumer stalled, second pulse after hold-off gets dropped
        clear_stim(120, 1'b0);
        put_pulse(9, 50, 150, 300, 300, 200, 90);
        s[35] = 150; s[36] = 400; s[37] = 90;
        for (int j = 60; j < 120; j++) r[j] = 1'b1;
        run_scenario(100, 120);
        // second pulse inside hold-off is ignored
        clear_stim(100, 1'b1);
        put_pulse(9, 50, 150, 300, 300, 200, 90);
        s[20] = 200; s[21] = 300; s[22] = 90;
        run_scenario(100, 100);
        // reset in the middle of a pulse, then a fresh pulse
        reset_mid_track();
        clear_stim(60, 1'b1);
        s[7] = 200; s[8] = 400; s[9] = 150;
        run_scenario(100, 60);
`ifdef PEAK_PILEUP_EN
        clear_stim(200, 1'b1);
        for (int j = 10; j < 80; j++) s[j] = 500;
        for (int j = 120; j < 130; j++) s[j] = 500;
        run_scenario(100, 200);
`endif
        for (int k = 0; k < 6; k++) begin
            thr = int'($urandom_range(0, 500)) - 200;
            gen_random(thr, NMAX);
            run_scenario(thr, NMAX);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/filter_peak_extractor.md
Name: filter_peak_extractor

Overview:
- Sits directly downstream of the trapezoidal shaping filter and consumes its signed output every clock.
- Detects threshold crossings and tracks the flat-top maximum of each shaped pulse.
- Emits one event per pulse: amplitude, timestamp of peak, pulse width.
- Events go out through a valid/ready handshake toward readout, with single-event buffering, hold-off dead time and drop counting.

Parameters:
- DATA_W, 20: width of signed filter samples; matches filter output width.
- TS_W, 32: width of free-running timestamp counter.
- WIDTH_W, 8: width of pulse-width field; saturates at all-ones.
- HOLDOFF, 16: dead-time cycles after each event before re-arm is allowed; legal range 0..255.
- MAX_WIDTH, 64: pulse-width limit used by the optional pile-up check.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- filt_data  in  DATA_W  signed shaped sample from filter; valid every clock.
- threshold  in  DATA_W  signed trigger level; quasi-static.
- out_amp  out  DATA_W  signed peak amplitude of the event.
- out_ts  out  TS_W  timestamp-counter value at the cycle the peak sample was presented.
- out_width  out  WIDTH_W  number of samples strictly above threshold.
- out_valid  out  1  event available.
- out_ready  in  1  consumer accepts event.
- drop_cnt  out  16  saturating count of events lost because the output was still occupied.
- busy  out  1  high in TRACK or HOLDOFF.

Behaviour:
- Reset values: out_amp=0, out_ts=0, out_width=0, out_valid=0, drop_cnt=0, busy=0, ts counter=0, FSM=IDLE.
- Timestamp counter increments every clock from 0 after reset release and wraps modulo 2^TS_W.
- FSM states: IDLE, TRACK, HOLDOFF. Each transition below is evaluated against the sample presented in the current cycle.
- IDLE:
  - If filt_data > threshold (signed, strict): go to TRACK.
  - On entry: max=filt_data, peak_ts=counter, width=1, and threshold is latched for the rest of the event.
- TRACK:
  - If filt_data > latched threshold: width+=1 (saturating).
  - If filt_data > max (strict): update max and peak_ts, so the first sample of a flat top wins the timestamp.
  - If filt_data <= latched threshold: event complete; post it and go to HOLDOFF with hold counter=0.
- HOLDOFF:
  - Input is ignored; the hold counter increments each cycle.
  - When the counter reaches HOLDOFF and filt_data <= threshold: go to IDLE.
  - If the signal is still above threshold at that point, stay in HOLDOFF until it falls; no retrigger on the tail.
  - HOLDOFF=0: the below-threshold check is still required, so the minimum stay is 1 cycle.
- Posting:
  - out_* registers load on the clock edge following the first below-threshold sample.
  - out_valid rises at that edge, i.e. 1 cycle after the terminating sample.
- Handshake:
  - Transfer occurs when out_valid && out_ready at a clock edge.
  - out_* hold stable while out_valid=1 and no transfer has occurred.
  - out_valid falls after a transfer unless a new event posts in the same cycle.
- Simultaneous post and transfer: the new event loads and out_valid stays 1; no drop.
- Post while out_valid=1 with no transfer: the new event is discarded, the old one is kept, and drop_cnt increments, saturating at 0xFFFF.
- Counter wrap: out_ts reflects the wrapped value; no special handling.
- Reset asserted mid-event: the event is lost, all outputs return to reset values asynchronously, and no partial event is emitted after release.
- A change in threshold during TRACK has no effect until the next IDLE.

Optional Feature:
- Macro: PEAK_PILEUP_EN.
- Defined:
  - Adds output out_pileup (1 bit, reset 0), registered alongside the other out_* signals.
  - out_pileup=1 when the event width exceeds MAX_WIDTH, or when the sample sequence in TRACK rises again by more than (max-threshold)/2 after a fall of the same size (double peak).
  - Pile-up events are still posted.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, threshold=100, filt_data held at 0 for 50 cycles -> out_valid=0, drop_cnt=0, busy=0.
- Threshold=100, pulse 0,50,150,300,300,200,90,0 with the first 150 at counter=10 -> one event: out_amp=300, out_ts=11 (first 300), out_width=4; out_valid rises the cycle after the 90 sample.
- Same pulse, out_ready=0 throughout, second pulse 20 cycles later (HOLDOFF=16) -> first event retained, drop_cnt=1; raising out_ready gives exactly one transfer of out_amp=300.
- Second pulse starting 5 cycles after the first ends (HOLDOFF=16) -> ignored: no event, drop_cnt unchanged, busy=1 throughout.
- Reset pulled low during TRACK with amplitude 250 -> all outputs 0 immediately; after release, a fresh pulse peaking at 400 yields out_amp=400, with the timestamp counted from the release.
- PEAK_PILEUP_EN: 70-sample plateau at 500, threshold=100 -> out_width=70, out_pileup=1; a 10-sample pulse gives out_pileup=0.
